// File: rtl/stage_collision_detector.sv
// Stage collision detector: free-running scan that turns one player's
// position into the wall vector and KO flag for the physics coprocessor.
//
// Ports:
//   slowClock  : clock
//   reset      : synchronous, active-high reset
//   position   : [31:16] x (hitbox centre), [15:0] y (feet), signed
//   plat_table : NUM_PLAT entries of {x0, x1, y}, entry i at [48i+47:48i]
//   drop_in    : player requests drop-through of pass-through platforms
//   wall       : bit0 up, bit1 down, bit2 right, bit3 left, bit4 platform
//   ko         : hitbox origin outside the blast zone
//   update     : one-cycle pulse when wall/ko refresh
module stage_collision_detector #(
    parameter int NUM_PLAT  = 3,
    parameter int HALF_W    = 8,
    parameter int HEIGHT    = 24,
    parameter int TOL       = 2,
    parameter int STAGE_X0  = 40,
    parameter int STAGE_X1  = 280,
    parameter int STAGE_TOP = 60,
    parameter int CEIL      = 230,
    parameter int BLAST_L   = -64,
    parameter int BLAST_R   = 383,
    parameter int BLAST_B   = -64,
    parameter int BLAST_T   = 303,
    parameter int DROP_HOLD = 8
) (
    input  logic                    slowClock,
    input  logic                    reset,
    input  logic [31:0]             position,
    input  logic [48*NUM_PLAT-1:0]  plat_table,
    input  logic                    drop_in,
    output logic [31:0]             wall,
    output logic                    ko,
    output logic                    update
);

    localparam int DW = (DROP_HOLD < 1) ? 1 : $clog2(DROP_HOLD + 1);

    localparam logic signed [16:0] C_HW  = 17'(HALF_W);
    localparam logic signed [16:0] C_HT  = 17'(HEIGHT);
    localparam logic signed [16:0] C_TOL = 17'(TOL);
    localparam logic signed [16:0] C_SX0 = 17'(STAGE_X0);
    localparam logic signed [16:0] C_SX1 = 17'(STAGE_X1);
    localparam logic signed [16:0] C_TOP = 17'(STAGE_TOP);
    localparam logic signed [16:0] C_CEI = 17'(CEIL);
    localparam logic signed [16:0] C_BL  = 17'(BLAST_L);
    localparam logic signed [16:0] C_BR  = 17'(BLAST_R);
    localparam logic signed [16:0] C_BB  = 17'(BLAST_B);
    localparam logic signed [16:0] C_BT  = 17'(BLAST_T);

    typedef enum logic [1:0] {
        LATCH,
        SCAN,
        PUBLISH
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [31:0]       pos_q, pos_d;
    logic              acc_q, acc_d;
    logic [3:0]        stg_q, stg_d;
    logic              kob_q, kob_d;
    logic [DW-1:0]     drop_q, drop_d;
    logic [31:0]       wall_q, wall_d;
    logic              ko_q, ko_d;
    logic              upd_q, upd_d;

    function automatic logic signed [16:0] sx(input logic [15:0] v);
        return {v[15], v};
    endfunction

    logic signed [16:0] px, py, l, r, t;
    logic signed [16:0] ex0, ex1, ey;
    logic [47:0]        ent;
    logic               hit, up_b, dn_b, rt_b, lf_b, ko_b, low;

    // Table entry under the scan index
    always_comb begin
        ent = '0;
        for (int i = 0; i < NUM_PLAT; i++) begin
            if (idx_q == 4'(i)) begin
                ent = plat_table[48*i +: 48];
            end
        end
    end

    always_comb begin
        px   = sx(pos_q[31:16]);
        py   = sx(pos_q[15:0]);
        l    = px - C_HW;
        r    = px + C_HW;
        t    = py + C_HT;
        ex0  = sx(ent[47:32]);
        ex1  = sx(ent[31:16]);
        ey   = sx(ent[15:0]);
        hit  = (l <= ex1) && (r >= ex0)
            && (ey - C_TOL <= py) && (py <= ey);
        // Side faces only count below the standing band
        low  = py < C_TOP - C_TOL;
        dn_b = (l <= C_SX1) && (r >= C_SX0)
            && (C_TOP - C_TOL <= py) && (py <= C_TOP);
        lf_b = low && (C_SX1 - C_TOL <= l) && (l <= C_SX1);
        rt_b = low && (C_SX0 <= r) && (r <= C_SX0 + C_TOL);
        up_b = t >= C_CEI;
        ko_b = (px < C_BL) || (px > C_BR)
            || (py < C_BB) || (py > C_BT);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        acc_d   = acc_q;
        stg_d   = stg_q;
        kob_d   = kob_q;
        drop_d  = drop_q;
        wall_d  = wall_q;
        ko_d    = ko_q;
        upd_d   = 1'b0;
        unique case (state_q)
            LATCH: begin
                pos_d   = position;
                acc_d   = 1'b0;
                idx_d   = '0;
                state_d = SCAN;
            end
            SCAN: begin
                acc_d = acc_q | hit;
                stg_d = {lf_b, rt_b, dn_b, up_b};
                kob_d = ko_b;
                if (idx_q == 4'(NUM_PLAT - 1)) begin
                    idx_d   = '0;
                    state_d = PUBLISH;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            PUBLISH: begin
                wall_d = {27'd0, 1'b0, stg_q};
                if (drop_in && acc_q) begin
                    drop_d = DW'(DROP_HOLD);
                end else if (drop_q != '0) begin
                    drop_d = drop_q - DW'(1);
                end else begin
                    wall_d[4] = acc_q;
                end
                ko_d    = kob_q;
                upd_d   = 1'b1;
                state_d = LATCH;
            end
            default: state_d = LATCH;
        endcase
    end

    always_ff @(posedge slowClock) begin
        if (reset) begin
            state_q <= LATCH;
            idx_q   <= '0;
            pos_q   <= '0;
            acc_q   <= 1'b0;
            stg_q   <= '0;
            kob_q   <= 1'b0;
            drop_q  <= '0;
            wall_q  <= '0;
            ko_q    <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            acc_q   <= acc_d;
            stg_q   <= stg_d;
            kob_q   <= kob_d;
            drop_q  <= drop_d;
            wall_q  <= wall_d;
            ko_q    <= ko_d;
            upd_q   <= upd_d;
        end
    end

    assign wall   = wall_q;
    assign ko     = ko_q;
    assign update = upd_q;

endmodule
